// File: rtl/fetch_redirect_unit_if.sv
// Fetch-stage bus between the pipeline control logic and the PC sequencer.
// The master side is the hazard/execute/decode logic. It drives stalls,
// redirects and halts. The slave side is the fetch redirect unit.
interface fetch_redirect_unit_if #(
  parameter int PC_WIDTH = 32
);

  logic                stallF;
  logic                PCSrc;
  logic [PC_WIDTH-1:0] branchTarget;
  logic                haltD;
  logic [PC_WIDTH-1:0] pcF;
  logic [PC_WIDTH-1:0] pcPlusStepF;
  logic                flushD;
  logic                flushE;
  logic                fetchValid;
  logic                halted;

  modport master (
    output stallF, PCSrc, branchTarget, haltD,
    input  pcF, pcPlusStepF, flushD, flushE, fetchValid, halted
  );

  modport slave (
    input  stallF, PCSrc, branchTarget, haltD,
    output pcF, pcPlusStepF, flushD, flushE, fetchValid, halted
  );

endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC sequencer.
// It owns the PC and steers fetch to taken-branch targets. After a redirect it
// flushes the wrong-path D/E instructions. It masks fetchValid while the
// instruction memory refills, and it freezes fetch after a decoded halt.
module fetch_redirect_unit #(
  parameter int                  PC_WIDTH      = 32,
  parameter int                  PC_STEP       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter int                  REFILL_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  fetch_redirect_unit_if.slave bus
);

  localparam int CNT_W = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);
  localparam logic [CNT_W-1:0]    REFILL_LOAD = CNT_W'(REFILL_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [PC_WIDTH-1:0] STEP        = PC_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    REFILL = 2'd2,
    HALT   = 2'd3
  } stateT;

  stateT               state;
  logic [PC_WIDTH-1:0] pcReg;
  logic [CNT_W-1:0]    refillCnt;
  logic                redirect;

  // A taken branch counts only while fetch is live (RUN or REFILL).
  assign redirect = bus.PCSrc && ((state == RUN) || (state == REFILL));

  assign bus.pcF         = pcReg;
  assign bus.pcPlusStepF = pcReg + STEP;
  assign bus.flushE      = redirect;
  assign bus.flushD      = redirect || (state == HALT) || ((state == RUN) && bus.haltD);
  assign bus.fetchValid  = (state == RUN);
  assign bus.halted      = (state == HALT);

  // Sequencer: the PC register, the refill countdown and the BOOT/RUN/REFILL/HALT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      pcReg     <= RESET_PC;
      refillCnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.PCSrc) begin
            pcReg     <= bus.branchTarget;
            refillCnt <= REFILL_LOAD;
            state     <= REFILL;
          end else if (bus.haltD) begin
            state <= HALT;
          end else if (!bus.stallF) begin
            pcReg <= pcReg + STEP;
          end
        end
        REFILL: begin
          if (bus.PCSrc) begin
            pcReg     <= bus.branchTarget;
            refillCnt <= REFILL_LOAD;
          end else if (!bus.stallF) begin
            pcReg     <= pcReg + STEP;
            refillCnt <= refillCnt - CNT_ONE;
            if (refillCnt == CNT_ONE) begin
              state <= RUN;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit.
// It drives a 32-bit instance through redirect, stall, halt and reset
// sequences. An 8-bit instance that resets to 0xFC checks that the PC
// wraps around.
module tb_fetch_redirect_unit;

  logic clk;
  logic reset;

  int errors;
  int checks;

  fetch_redirect_unit_if #(.PC_WIDTH(32)) bus ();
  fetch_redirect_unit_if #(.PC_WIDTH(8))  bus8 ();

  fetch_redirect_unit #(
    .PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0), .REFILL_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  fetch_redirect_unit #(
    .PC_WIDTH(8), .PC_STEP(4), .RESET_PC(8'hFC), .REFILL_CYCLES(1)
  ) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic pcsrc,
                               input logic [31:0] target, input logic halt);
    bus.stallF       = stall;
    bus.PCSrc        = pcsrc;
    bus.branchTarget = target;
    bus.haltD        = halt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence, each step checked against hand-computed values.
  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus8.stallF = 1'b0; bus8.PCSrc = 1'b0; bus8.branchTarget = 8'h0; bus8.haltD = 1'b0;
    applyStimulus(0, 0, 32'h0, 0);

    // Reset values while reset is held.
    #11;
    checkOutput("rst_pc",      bus.pcF, 32'h0);
    checkOutput("rst_pcplus",  bus.pcPlusStepF, 32'h4);
    checkOutput("rst_valid",   32'(bus.fetchValid), 0);
    checkOutput("rst_halted",  32'(bus.halted), 0);
    checkOutput("rst_flushD",  32'(bus.flushD), 0);
    checkOutput("rst_flushE",  32'(bus.flushE), 0);
    checkOutput("rst_pc8",     32'(bus8.pcF), 32'hFC);

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("boot_pc",    bus.pcF, 32'h0);
    checkOutput("boot_valid", 32'(bus.fetchValid), 0);

    // First RUN cycle, sequential fetch, 8-bit wrap.
    tick();
    checkOutput("run0_pc",     bus.pcF, 32'h0);
    checkOutput("run0_valid",  32'(bus.fetchValid), 1);
    checkOutput("run0_pc8",    32'(bus8.pcF), 32'hFC);
    checkOutput("run0_plus8",  32'(bus8.pcPlusStepF), 32'h00);
    tick();
    checkOutput("run1_pc",     bus.pcF, 32'h4);
    checkOutput("wrap_pc8",    32'(bus8.pcF), 32'h00);
    checkOutput("wrap_plus8",  32'(bus8.pcPlusStepF), 32'h04);
    tick();
    tick();
    tick();
    checkOutput("run4_pc",     bus.pcF, 32'h10);

    // Redirect at 0x10 to 0x40.
    applyStimulus(0, 1, 32'h40, 0);
    checkOutput("br_flushD",   32'(bus.flushD), 1);
    checkOutput("br_flushE",   32'(bus.flushE), 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("refill_pc",    bus.pcF, 32'h40);
    checkOutput("refill_valid", 32'(bus.fetchValid), 0);
    checkOutput("refill_flushE", 32'(bus.flushE), 0);
    tick();
    checkOutput("post_pc",     bus.pcF, 32'h44);
    checkOutput("post_valid",  32'(bus.fetchValid), 1);

    // Move to 0x20 (redirect to 0x1C, one refill step), then stall 3 cycles.
    applyStimulus(0, 1, 32'h1C, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    tick();
    checkOutput("at20_pc",     bus.pcF, 32'h20);
    applyStimulus(1, 0, 32'h0, 0);
    checkOutput("stall_flushD", 32'(bus.flushD), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_pc",    bus.pcF, 32'h20);
      checkOutput("stall_valid", 32'(bus.fetchValid), 1);
    end

    // Stall and redirect together: the redirect wins.
    applyStimulus(1, 1, 32'h80, 0);
    checkOutput("stbr_flushE", 32'(bus.flushE), 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("stbr_pc",     bus.pcF, 32'h80);
    tick();
    checkOutput("stbr_post",   bus.pcF, 32'h84);

    // Move to 0x30, then halt.
    applyStimulus(0, 1, 32'h2C, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    tick();
    checkOutput("at30_pc",     bus.pcF, 32'h30);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("hlt_flushD",  32'(bus.flushD), 1);
    checkOutput("hlt_flushE",  32'(bus.flushE), 0);
    checkOutput("hlt_pre",     32'(bus.halted), 0);
    tick();
    checkOutput("halt_flag",   32'(bus.halted), 1);
    checkOutput("halt_pc",     bus.pcF, 32'h30);
    checkOutput("halt_flushD", 32'(bus.flushD), 1);
    checkOutput("halt_valid",  32'(bus.fetchValid), 0);
    applyStimulus(1, 1, 32'h99, 0);
    checkOutput("halt_noflE",  32'(bus.flushE), 0);
    tick();
    checkOutput("halt_br_pc",  bus.pcF, 32'h30);
    checkOutput("halt_stay",   32'(bus.halted), 1);

    // Async reset mid-HALT, between edges.
    #3;
    reset = 1'b0;
    #1;
    checkOutput("hrst_pc",     bus.pcF, 32'h0);
    checkOutput("hrst_halted", 32'(bus.halted), 0);
    checkOutput("hrst_flushD", 32'(bus.flushD), 0);
    checkOutput("hrst_flushE", 32'(bus.flushE), 0);
    applyStimulus(0, 0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("rerun_pc",    bus.pcF, 32'h0);
    tick();
    checkOutput("rerun_pc4",   bus.pcF, 32'h4);

    // Halt and redirect together: the redirect wins.
    applyStimulus(0, 1, 32'h100, 1);
    checkOutput("hb_flushE",   32'(bus.flushE), 1);
    tick();
    checkOutput("hb_pc",       bus.pcF, 32'h100);
    checkOutput("hb_halted",   32'(bus.halted), 0);
    // A second redirect during REFILL restarts it.
    applyStimulus(0, 1, 32'h200, 0);
    checkOutput("rb_flushE",   32'(bus.flushE), 1);
    checkOutput("rb_flushD",   32'(bus.flushD), 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("rb_pc",       bus.pcF, 32'h200);
    checkOutput("rb_valid",    32'(bus.fetchValid), 0);
    tick();
    checkOutput("rb_post",     bus.pcF, 32'h204);
    checkOutput("rb_pvalid",   32'(bus.fetchValid), 1);

    // Stall holds REFILL. Halt is ignored during REFILL.
    applyStimulus(0, 1, 32'h300, 0);
    tick();
    applyStimulus(1, 0, 32'h0, 1);
    checkOutput("rf_noflushD", 32'(bus.flushD), 0);
    tick();
    checkOutput("rfst_pc",     bus.pcF, 32'h300);
    checkOutput("rfst_valid",  32'(bus.fetchValid), 0);
    applyStimulus(0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("rfh_pc",      bus.pcF, 32'h304);
    checkOutput("rfh_halted",  32'(bus.halted), 0);
    checkOutput("rfh_valid",   32'(bus.fetchValid), 1);
    tick();
    checkOutput("rfh_next",    bus.pcF, 32'h308);

    // Async reset mid-REFILL, between edges.
    applyStimulus(0, 1, 32'h500, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("rr_pc",       bus.pcF, 32'h500);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rrst_pc",     bus.pcF, 32'h0);
    checkOutput("rrst_valid",  32'(bus.fetchValid), 0);
    checkOutput("rrst_flushD", 32'(bus.flushD), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("rrun_pc",     bus.pcF, 32'h0);
    checkOutput("rrun_valid",  32'(bus.fetchValid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
